// File: rtl/jelly2_video_frame_normalizer_pkg.sv
// Shared types for the video frame normalizer.
// Contents: state_t, the normalizer FSM states.
// No ports; imported by jelly2_video_frame_normalizer.
package jelly2_video_frame_normalizer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAD_LINE  = 3'd2,
    SKIP_LINE = 3'd3,
    PAD_FRAME = 3'd4
  } state_t;

endpackage

// File: rtl/jelly2_video_frame_normalizer.sv
// Purpose : forces every AXI4-Stream video frame to exactly param_width x param_height pixels.
// Latency : 1 cycle from input acceptance to m_axi4s_tvalid (single output register).
// Backpr. : s_axi4s_tready = state-permits && (!m_tvalid || m_tready), combinational from m_tready.
// Ports   : aclk/aresetn clock and async active-low reset; enable gates new frames (sampled in IDLE);
//           param_width/height/fill latched at frame start (0 size treated as 1); busy = not idle;
//           err_* one-cycle error pulses; s_axi4s_* input stream (tuser = frame start); m_axi4s_* output.
module jelly2_video_frame_normalizer
  import jelly2_video_frame_normalizer_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int X_WIDTH    = 12,
  parameter int Y_WIDTH    = 12
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  output logic                  busy,
  input  logic [X_WIDTH-1:0]    param_width,
  input  logic [Y_WIDTH-1:0]    param_height,
  input  logic [DATA_WIDTH-1:0] param_fill,
  output logic                  err_short_line,
  output logic                  err_long_line,
  output logic                  err_short_frame,
  input  logic [0:0]            s_axi4s_tuser,
  input  logic                  s_axi4s_tlast,
  input  logic [DATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                  s_axi4s_tvalid,
  output logic                  s_axi4s_tready,
  output logic [0:0]            m_axi4s_tuser,
  output logic                  m_axi4s_tlast,
  output logic [DATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                  m_axi4s_tvalid,
  input  logic                  m_axi4s_tready
);

  localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);

  state_t                  r_state;
  logic [X_WIDTH-1:0]      r_x;
  logic [Y_WIDTH-1:0]      r_y;
  logic [X_WIDTH-1:0]      r_wm1;
  logic [Y_WIDTH-1:0]      r_hm1;
  logic [DATA_WIDTH-1:0]   r_fill;
  logic                    r_rdy_en;
  logic                    r_m_tuser;
  logic                    r_m_tlast;
  logic [DATA_WIDTH-1:0]   r_m_tdata;
  logic                    r_m_tvalid;
  logic                    r_err_short_line;
  logic                    r_err_long_line;
  logic                    r_err_short_frame;

  logic                    w_out_ok;
  logic                    w_start;
  logic                    w_sof_seen;
  logic [X_WIDTH-1:0]      w_wm1;
  logic [Y_WIDTH-1:0]      w_hm1;
  logic                    w_x_last;
  logic                    w_y_last;
  logic                    w_s_tready;
  logic                    w_accept;
  logic                    w_beat;
  logic                    w_pad;

  assign w_out_ok   = !r_m_tvalid || m_axi4s_tready;
  assign w_start    = s_axi4s_tvalid && s_axi4s_tuser[0] && enable;
  assign w_sof_seen = s_axi4s_tvalid && s_axi4s_tuser[0];

  // In IDLE the frame geometry comes straight from the params so the first
  // pixel is judged against the values being latched in the same cycle.
  assign w_wm1 = (r_state == IDLE) ? ((param_width  == '0) ? '0 : param_width  - X_ONE) : r_wm1;
  assign w_hm1 = (r_state == IDLE) ? ((param_height == '0) ? '0 : param_height - Y_ONE) : r_hm1;

  assign w_x_last = (r_x == w_wm1);
  assign w_y_last = (r_y == w_hm1);

  always_comb begin
    w_s_tready = 1'b0;
    if (r_rdy_en) begin
      case (r_state)
        IDLE:      w_s_tready = w_start ? w_out_ok : 1'b1;   // non-start beats are dropped
        RUN:       w_s_tready = !w_sof_seen && w_out_ok;     // a new tuser is held for the next frame
        SKIP_LINE: w_s_tready = !w_sof_seen;
        default:   w_s_tready = 1'b0;
      endcase
    end
  end

  assign w_accept = s_axi4s_tvalid && w_s_tready;
  assign w_beat   = w_accept && ((r_state == RUN) || ((r_state == IDLE) && w_start));
  assign w_pad    = ((r_state == PAD_LINE) || (r_state == PAD_FRAME)) && w_out_ok;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state           <= IDLE;
      r_x               <= '0;
      r_y               <= '0;
      r_wm1             <= '0;
      r_hm1             <= '0;
      r_fill            <= '0;
      r_rdy_en          <= 1'b0;
      r_m_tuser         <= 1'b0;
      r_m_tlast         <= 1'b0;
      r_m_tdata         <= '0;
      r_m_tvalid        <= 1'b0;
      r_err_short_line  <= 1'b0;
      r_err_long_line   <= 1'b0;
      r_err_short_frame <= 1'b0;
    end else begin
      r_rdy_en          <= 1'b1;
      r_err_short_line  <= 1'b0;
      r_err_long_line   <= 1'b0;
      r_err_short_frame <= 1'b0;

      if (r_m_tvalid && m_axi4s_tready) begin
        r_m_tvalid <= 1'b0;
      end

      if (w_beat && (r_state == IDLE)) begin
        r_wm1  <= w_wm1;
        r_hm1  <= w_hm1;
        r_fill <= param_fill;
      end

      if (w_beat || w_pad) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_beat ? s_axi4s_tdata : r_fill;
        r_m_tuser  <= (r_x == '0) && (r_y == '0);
        r_m_tlast  <= w_x_last;
        if (w_x_last) begin
          r_x <= '0;
          if (w_beat && !s_axi4s_tlast) begin
            r_err_long_line <= 1'b1;
          end
          if (w_y_last) begin
            r_y     <= '0;
            r_state <= IDLE;
          end else begin
            r_y <= r_y + Y_ONE;
            if (r_state == PAD_FRAME) begin
              r_state <= PAD_FRAME;
            end else if (w_beat && !s_axi4s_tlast) begin
              r_state <= SKIP_LINE;
            end else begin
              r_state <= RUN;
            end
          end
        end else begin
          r_x <= r_x + X_ONE;
          if (w_beat && s_axi4s_tlast) begin
            r_err_short_line <= 1'b1;
            r_state          <= PAD_LINE;
          end else if (w_beat) begin
            r_state <= RUN;
          end
        end
      end

      // A premature frame start is never consumed here; it is replayed once
      // the current frame has been filled out.
      if (((r_state == RUN) || (r_state == SKIP_LINE)) && w_sof_seen) begin
        r_err_short_frame <= 1'b1;
        r_state           <= PAD_FRAME;
      end

      if ((r_state == SKIP_LINE) && w_accept && s_axi4s_tlast) begin
        r_state <= RUN;
      end
    end
  end

  assign busy            = (r_state != IDLE);
  assign s_axi4s_tready  = w_s_tready;
  assign m_axi4s_tuser   = r_m_tuser;
  assign m_axi4s_tlast   = r_m_tlast;
  assign m_axi4s_tdata   = r_m_tdata;
  assign m_axi4s_tvalid  = r_m_tvalid;
  assign err_short_line  = r_err_short_line;
  assign err_long_line   = r_err_long_line;
  assign err_short_frame = r_err_short_frame;

endmodule

// File: tb/tb_jelly2_video_frame_normalizer.sv
// Purpose : directed scoreboard bench for jelly2_video_frame_normalizer.
// Latency : expected beats are queued at drive time and matched as the DUT emits them.
// Backpr. : m_axi4s_tready is held high, randomised or held low depending on the step.
module tb_jelly2_video_frame_normalizer;

  localparam int DW = 10;
  localparam int XW = 12;
  localparam int YW = 12;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          enable;
  logic          busy;
  logic [XW-1:0] param_width;
  logic [YW-1:0] param_height;
  logic [DW-1:0] param_fill;
  logic          err_short_line;
  logic          err_long_line;
  logic          err_short_frame;
  logic [0:0]    s_axi4s_tuser;
  logic          s_axi4s_tlast;
  logic [DW-1:0] s_axi4s_tdata;
  logic          s_axi4s_tvalid;
  logic          s_axi4s_tready;
  logic [0:0]    m_axi4s_tuser;
  logic          m_axi4s_tlast;
  logic [DW-1:0] m_axi4s_tdata;
  logic          m_axi4s_tvalid;
  logic          m_axi4s_tready;

  jelly2_video_frame_normalizer #(.DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .enable          (enable),
    .busy            (busy),
    .param_width     (param_width),
    .param_height    (param_height),
    .param_fill      (param_fill),
    .err_short_line  (err_short_line),
    .err_long_line   (err_long_line),
    .err_short_frame (err_short_frame),
    .s_axi4s_tuser   (s_axi4s_tuser),
    .s_axi4s_tlast   (s_axi4s_tlast),
    .s_axi4s_tdata   (s_axi4s_tdata),
    .s_axi4s_tvalid  (s_axi4s_tvalid),
    .s_axi4s_tready  (s_axi4s_tready),
    .m_axi4s_tuser   (m_axi4s_tuser),
    .m_axi4s_tlast   (m_axi4s_tlast),
    .m_axi4s_tdata   (m_axi4s_tdata),
    .m_axi4s_tvalid  (m_axi4s_tvalid),
    .m_axi4s_tready  (m_axi4s_tready)
  );

  always #5 aclk = ~aclk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            hs_cnt = 0;
  int            tr_mode = 0;   // 0: ready high, 1: random, 2: held low
  int            cnt_sl = 0;
  int            cnt_ll = 0;
  int            cnt_sf = 0;
  int            last_wait = 0;
  logic [DW+1:0] exp_q[$];      // {tuser, tlast, tdata}

  // Input handshakes counted with pre-edge values.
  always @(posedge aclk) begin
    if (s_axi4s_tvalid && s_axi4s_tready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic u, input logic l, input logic [DW-1:0] d);
    exp_q.push_back({u, l, d});
  endtask

  task automatic send(input logic u, input logic l, input logic [DW-1:0] d);
    int start;
    int waited;
    start  = hs_cnt;
    waited = 0;
    s_axi4s_tuser  = u;
    s_axi4s_tlast  = l;
    s_axi4s_tdata  = d;
    s_axi4s_tvalid = 1'b1;
    while ((hs_cnt == start) && (waited < 300)) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    s_axi4s_tvalid = 1'b0;
    last_wait = waited;
    check("send_accept", 32'(hs_cnt != start), 32'd1);
  endtask

  task automatic send_frame(input int w, input int h, input int base);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        logic u;
        logic l;
        logic [DW-1:0] d;
        u = (xx == 0) && (yy == 0);
        l = (xx == w - 1);
        d = DW'(base + yy * w + xx);
        exp_push(u, l, d);
        send(u, l, d);
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (((exp_q.size() != 0) || m_axi4s_tvalid) && (n < 2000)) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [DW+1:0] got;
    logic [DW+1:0] want;
    aresetn        = 1'b0;
    enable         = 1'b0;
    param_width    = XW'(4);
    param_height   = YW'(2);
    param_fill     = DW'(10'h3AA);
    s_axi4s_tuser  = 1'b0;
    s_axi4s_tlast  = 1'b0;
    s_axi4s_tdata  = '0;
    s_axi4s_tvalid = 1'b0;
    m_axi4s_tready = 1'b0;

    fork
      forever begin
        @(posedge aclk);
        #1;
        case (tr_mode)
          0:       m_axi4s_tready = 1'b1;
          1:       m_axi4s_tready = 1'($urandom_range(0, 1));
          default: m_axi4s_tready = 1'b0;
        endcase
      end
      forever begin
        @(negedge aclk);
        if (aresetn) begin
          cnt_sl += int'(err_short_line);
          cnt_ll += int'(err_long_line);
          cnt_sf += int'(err_short_frame);
          if (m_axi4s_tvalid && m_axi4s_tready) begin
            check("out_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              got  = {m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata};
              want = exp_q.pop_front();
              check("out_beat", 32'(got), 32'(want));
            end
          end
        end
      end
    join_none

    // Reset state
    #3;
    check("rst_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_axi4s_tready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errs", 32'({err_short_line, err_long_line, err_short_frame}), 32'd0);
    #19 aresetn = 1'b1;
    #1;
    check("post_rst_tready_low", 32'(s_axi4s_tready), 32'd0);
    @(posedge aclk);
    #1;
    check("post_rst_tready_high", 32'(s_axi4s_tready), 32'd1);
    enable = 1'b1;

    // Two clean frames, random backpressure
    tr_mode = 1;
    send_frame(4, 2, 'h010);
    send_frame(4, 2, 'h040);
    wait_drain();
    check("clean_errs", 32'(cnt_sl + cnt_ll + cnt_sf), 32'd0);

    // Short line 0; params changed after start must not matter
    exp_push(1'b1, 1'b0, DW'('h080));
    send(1'b1, 1'b0, DW'('h080));
    check("busy_in_frame", 32'(busy), 32'd1);
    param_width = XW'(9);
    param_fill  = DW'(0);
    exp_push(1'b0, 1'b0, DW'('h081));
    exp_push(1'b0, 1'b0, DW'(10'h3AA));
    exp_push(1'b0, 1'b1, DW'(10'h3AA));
    send(1'b0, 1'b1, DW'('h081));
    for (int i = 0; i < 4; i++) begin
      exp_push(1'b0, (i == 3), DW'('h090 + i));
      send(1'b0, (i == 3), DW'('h090 + i));
    end
    wait_drain();
    check("short_line_err", 32'(cnt_sl), 32'd1);
    param_width = XW'(4);
    param_fill  = DW'(10'h3AA);

    // Long line 0: six pixels, last two dropped
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp_push((i == 0), (i == 3), DW'('h0A0 + i));
      send((i == 0), (i == 5), DW'('h0A0 + i));
    end
    for (int i = 0; i < 4; i++) begin
      exp_push(1'b0, (i == 3), DW'('h0B0 + i));
      send(1'b0, (i == 3), DW'('h0B0 + i));
    end
    wait_drain();
    check("long_line_err", 32'(cnt_ll), 32'd1);
    check("long_line_no_other", 32'(cnt_sl + cnt_sf), 32'd1);

    // Short frame: 4x3, new tuser after 5 pixels
    param_height = YW'(3);
    for (int i = 0; i < 5; i++) begin
      exp_push((i == 0), (i == 3), DW'('h0C0 + i));
      send((i == 0), (i == 3), DW'('h0C0 + i));
    end
    for (int i = 5; i < 12; i++) begin
      exp_push(1'b0, (i == 7) || (i == 11), DW'(10'h3AA));
    end
    send_frame(4, 3, 'h100);
    wait_drain();
    check("short_frame_err", 32'(cnt_sf), 32'd1);
    param_height = YW'(2);

    // Garbage before the first tuser is dropped immediately
    for (int i = 0; i < 10; i++) begin
      send(1'b0, (i % 3 == 2), DW'($urandom_range(0, 1023)));
      check("garbage_one_cycle", 32'(last_wait), 32'd1);
    end
    send_frame(4, 2, 'h140);
    wait_drain();

    // Reset mid-frame with output stalled
    tr_mode = 2;
    @(posedge aclk);
    #2;
    exp_push(1'b1, 1'b0, DW'('h180));
    send(1'b1, 1'b0, DW'('h180));
    @(posedge aclk);
    #1;
    check("stall_m_tvalid", 32'(m_axi4s_tvalid), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_m_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge aclk);
    #2 aresetn = 1'b1;
    tr_mode = 1;
    send_frame(4, 2, 'h1C0);
    wait_drain();
    check("final_err_totals", 32'({cnt_sl[7:0], cnt_ll[7:0], cnt_sf[7:0]}), 32'h010101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
